// File: rtl/rv_frontend.sv
// Instruction front end: PC generation, credit-bounded fetch requests to
// instruction memory, an in-order instruction queue, redirect flush and pre-decode.
module rv_frontend #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int              QDEPTH   = 4
) (
   input  logic            clk_i,
   input  logic            rst_i,
   output logic            req_valid_o,
   input  logic            req_ready_i,
   output logic [XLEN-1:0] req_addr_o,
   input  logic            rsp_valid_i,
   input  logic [31:0]     rsp_data_i,
   input  logic            redirect_i,
   input  logic [XLEN-1:0] redirect_pc_i,
   output logic            insn_valid_o,
   input  logic            insn_ready_i,
   output logic [31:0]     insn_o,
   output logic [XLEN-1:0] insn_pc_o,
   output logic [6:0]      opcode_o,
   output logic            illegal_o
);

   localparam int AW = $clog2(QDEPTH);
   localparam int CW = AW + 1;

   logic [XLEN-1:0] pc_reg;
   logic [CW-1:0]   count_reg;
   logic [CW-1:0]   outstanding_reg;
   logic [CW-1:0]   discard_reg;
   logic [AW-1:0]   head_reg;
   logic [AW-1:0]   tail_reg;
   logic [AW-1:0]   tag_wr_reg;
   logic [AW-1:0]   tag_rd_reg;

   logic [31:0]     insn_mem [QDEPTH];
   logic [XLEN-1:0] pc_mem   [QDEPTH];
   logic [XLEN-1:0] tag_mem  [QDEPTH];

   logic            credit_ok;
   logic            req_fire;
   logic            rsp_take;
   logic            push;
   logic            pop;
   logic [CW-1:0]   outstanding_next;
   logic [CW-1:0]   count_next;

   // Queued plus in-flight words never exceed the queue, so a push always has room.
   assign credit_ok = ({1'b0, count_reg} + {1'b0, outstanding_reg}) < (CW+1)'(QDEPTH);

   assign req_valid_o  = !rst_i && !redirect_i && credit_ok;
   assign req_addr_o   = rst_i ? RESET_PC : pc_reg;
   assign req_fire     = req_valid_o && req_ready_i;

   // Responses with nothing outstanding are a protocol violation and are ignored.
   assign rsp_take     = rsp_valid_i && (outstanding_reg != '0);
   assign push         = rsp_take && (discard_reg == '0) && !redirect_i;

   assign insn_valid_o = !rst_i && (count_reg != '0);
   assign pop          = insn_valid_o && insn_ready_i && !redirect_i;

   assign insn_o       = insn_mem[head_reg];
   assign insn_pc_o    = pc_mem[head_reg];
   assign opcode_o     = insn_o[6:0];
   assign illegal_o    = (insn_o[1:0] != 2'b11);

   assign outstanding_next = outstanding_reg + CW'(req_fire) - CW'(rsp_take);

   always_comb begin
      count_next = count_reg;
      case ({push, pop})
         2'b10:   count_next = count_reg + CW'(1);
         2'b01:   count_next = count_reg - CW'(1);
         default: count_next = count_reg;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pc_reg          <= RESET_PC;
         count_reg       <= '0;
         outstanding_reg <= '0;
         discard_reg     <= '0;
         head_reg        <= '0;
         tail_reg        <= '0;
         tag_wr_reg      <= '0;
         tag_rd_reg      <= '0;
      end else begin
         outstanding_reg <= outstanding_next;
         if (req_fire) begin
            tag_wr_reg <= tag_wr_reg + AW'(1);
         end
         if (rsp_take) begin
            tag_rd_reg <= tag_rd_reg + AW'(1);
         end
         if (redirect_i) begin
            // Every request still in flight after this cycle belongs to the old stream.
            pc_reg      <= redirect_pc_i & ~XLEN'(3);
            count_reg   <= '0;
            head_reg    <= '0;
            tail_reg    <= '0;
            discard_reg <= outstanding_reg - CW'(rsp_take);
         end else begin
            if (req_fire) begin
               pc_reg <= pc_reg + XLEN'(4);
            end
            if (rsp_take && (discard_reg != '0)) begin
               discard_reg <= discard_reg - CW'(1);
            end
            if (push) begin
               tail_reg <= tail_reg + AW'(1);
            end
            if (pop) begin
               head_reg <= head_reg + AW'(1);
            end
            count_reg <= count_next;
         end
      end
   end

   // Storage arrays carry no reset; pointers and counters define their validity.
   always_ff @(posedge clk_i) begin
      if (!rst_i && req_fire) begin
         tag_mem[tag_wr_reg] <= pc_reg;
      end
      if (!rst_i && push) begin
         insn_mem[tail_reg] <= rsp_data_i;
         pc_mem[tail_reg]   <= tag_mem[tag_rd_reg];
      end
   end

endmodule

// File: tb/tb_rv_frontend.sv
// Directed bench for rv_frontend: latency-programmable memory model, epoch-tagged
// scoreboard, and a second instance reset at 0xFFFFFFFC for the wrap case.
module tb_rv_frontend;

   localparam int          QD    = 4;
   localparam logic [31:0] RPC_A = 32'h0000_0100;
   localparam logic [31:0] RPC_B = 32'hFFFF_FFFC;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // instance A
   logic        rst, req_valid, req_ready, rsp_valid, redirect, insn_valid, insn_ready, illegal;
   logic [31:0] req_addr, rsp_data, redirect_pc, insn, insn_pc;
   logic [6:0]  opcode;
   // instance B
   logic        rst_b, req_valid_b, req_ready_b, rsp_valid_b, redirect_b, insn_valid_b, insn_ready_b, illegal_b;
   logic [31:0] req_addr_b, rsp_data_b, redirect_pc_b, insn_b, insn_pc_b;
   logic [6:0]  opcode_b;

   rv_frontend #(.XLEN(32), .RESET_PC(RPC_A), .QDEPTH(QD)) dut_a (
      .clk_i(clk), .rst_i(rst),
      .req_valid_o(req_valid), .req_ready_i(req_ready), .req_addr_o(req_addr),
      .rsp_valid_i(rsp_valid), .rsp_data_i(rsp_data),
      .redirect_i(redirect), .redirect_pc_i(redirect_pc),
      .insn_valid_o(insn_valid), .insn_ready_i(insn_ready), .insn_o(insn),
      .insn_pc_o(insn_pc), .opcode_o(opcode), .illegal_o(illegal)
   );

   rv_frontend #(.XLEN(32), .RESET_PC(RPC_B), .QDEPTH(QD)) dut_b (
      .clk_i(clk), .rst_i(rst_b),
      .req_valid_o(req_valid_b), .req_ready_i(req_ready_b), .req_addr_o(req_addr_b),
      .rsp_valid_i(rsp_valid_b), .rsp_data_i(rsp_data_b),
      .redirect_i(redirect_b), .redirect_pc_i(redirect_pc_b),
      .insn_valid_o(insn_valid_b), .insn_ready_i(insn_ready_b), .insn_o(insn_b),
      .insn_pc_o(insn_pc_b), .opcode_o(opcode_b), .illegal_o(illegal_b)
   );

   typedef struct { int due; logic [31:0] addr; int ep; } req_t;
   typedef struct { logic [31:0] insn; logic [31:0] pc; } ent_t;
   typedef struct { logic [31:0] pc; logic [6:0] opc; logic ill; int cyc; } pop_t;

   req_t        pend[$];
   ent_t        expq[$];
   pop_t        pops[$];
   logic [31:0] hs_addr[$];
   int          hs_cyc[$];
   logic [31:0] hsb_addr[$];

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          lat = 1;
   int          epoch = 0;
   logic [31:0] pc_model = RPC_A;
   logic        b_prev_v = 1'b0;
   logic [31:0] b_prev_a = '0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0000_4000) return 32'h0000_0013;
      if (a == 32'h0000_4004) return 32'h0000_4501;
      return (a * 32'h9E37_79B1) ^ 32'h1357_0000;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: memory responses, settle, monitor/scoreboard, advance to next negedge.
   task automatic step();
      req_t r;
      ent_t e;
      int   out_now;
      logic rv_exp;
      r = '{due: 0, addr: '0, ep: -1};
      rsp_valid = 1'b0;
      rsp_data  = '0;
      if (!rst && pend.size() != 0 && pend[0].due <= cyc) begin
         r = pend.pop_front();
         rsp_valid = 1'b1;
         rsp_data  = mem_word(r.addr);
      end
      rsp_valid_b = !rst_b && b_prev_v;
      rsp_data_b  = mem_word(b_prev_a);
      #1;
      if (rst) begin
         chk("a_rst_req_valid", req_valid, 0);
         chk("a_rst_insn_valid", insn_valid, 0);
         chk("a_rst_req_addr", req_addr, RPC_A);
         pend.delete();
         expq.delete();
         pc_model = RPC_A;
         epoch++;
      end else begin
         out_now = pend.size() + (rsp_valid ? 1 : 0);
         rv_exp  = !redirect && ((expq.size() + out_now) < QD);
         chk("a_req_valid", req_valid, rv_exp);
         if (req_valid) chk("a_req_addr", req_addr, pc_model);
         chk("a_insn_valid", insn_valid, expq.size() != 0);
         if (insn_valid && insn_ready && expq.size() != 0) begin
            e = expq.pop_front();
            chk("a_insn", insn, e.insn);
            chk("a_insn_pc", insn_pc, e.pc);
            chk("a_opcode", opcode, e.insn[6:0]);
            chk("a_illegal", illegal, e.insn[1:0] != 2'b11);
            pops.push_back('{pc: insn_pc, opc: opcode, ill: illegal, cyc: cyc});
         end
         if (rsp_valid && !redirect && r.ep == epoch) expq.push_back('{insn: rsp_data, pc: r.addr});
         if (redirect) begin
            expq.delete();
            epoch++;
            pc_model = {redirect_pc[31:2], 2'b00};
         end
         if (req_valid && req_ready) begin
            pend.push_back('{due: cyc + lat, addr: req_addr, ep: epoch});
            pc_model = pc_model + 32'd4;
            hs_addr.push_back(req_addr);
            hs_cyc.push_back(cyc);
         end
      end
      if (rst_b) begin
         chk("b_rst_req_valid", req_valid_b, 0);
         chk("b_rst_insn_valid", insn_valid_b, 0);
         chk("b_rst_req_addr", req_addr_b, RPC_B);
         b_prev_v = 1'b0;
      end else begin
         if (insn_valid_b) chk("b_insn", insn_b, mem_word(insn_pc_b));
         b_prev_v = req_valid_b;
         b_prev_a = req_addr_b;
         if (req_valid_b) hsb_addr.push_back(req_addr_b);
      end
      @(negedge clk);
      cyc++;
   endtask

   task automatic clear_logs();
      hs_addr.delete();
      hs_cyc.delete();
      pops.delete();
   endtask

   task automatic drain(input string tag);
      int n;
      insn_ready = 1'b1;
      req_ready  = 1'b0;
      n = 0;
      while ((pend.size() != 0 || expq.size() != 0) && n < 100) begin
         step();
         n++;
      end
      chk(tag, (pend.size() == 0 && expq.size() == 0), 1);
   endtask

   initial begin
      int   found;
      logic f0, f4;
      rst = 1'b1;  req_ready = 1'b1;  redirect = 1'b0;  redirect_pc = '0;  insn_ready = 1'b1;
      rst_b = 1'b1; req_ready_b = 1'b1; redirect_b = 1'b0; redirect_pc_b = '0; insn_ready_b = 1'b1;
      rsp_valid = 1'b0; rsp_data = '0; rsp_valid_b = 1'b0; rsp_data_b = '0;
      @(negedge clk);
      step();
      step();

      // Back-to-back fetch from RESET_PC with 1-cycle memory
      rst = 1'b0; rst_b = 1'b0; lat = 1;
      clear_logs();
      hsb_addr.delete();
      repeat (8) step();
      chk("t1_hs_count", hs_addr.size() >= 3, 1);
      if (hs_addr.size() >= 3) begin
         chk("t1_addr0", hs_addr[0], 32'h100);
         chk("t1_addr1", hs_addr[1], 32'h104);
         chk("t1_addr2", hs_addr[2], 32'h108);
         chk("t1_consec", hs_cyc[2] - hs_cyc[0], 2);
      end
      chk("t1_pop_count", pops.size() >= 3, 1);
      if (pops.size() >= 3 && hs_cyc.size() >= 1) begin
         chk("t1_first_latency", pops[0].cyc - hs_cyc[0], 2);
         chk("t1_pop_consec", pops[2].cyc - pops[0].cyc, 2);
      end
      chk("b_hs_count", hsb_addr.size() >= 2, 1);
      if (hsb_addr.size() >= 2) begin
         chk("b_addr0", hsb_addr[0], 32'hFFFF_FFFC);
         chk("b_addr1_wrap", hsb_addr[1], 32'h0000_0000);
      end

      // Stalled consumer: credit caps requests at QDEPTH
      drain("t2_drain");
      insn_ready = 1'b0; req_ready = 1'b1; lat = 3;
      clear_logs();
      repeat (12) step();
      chk("t2_hs_count_stalled", hs_addr.size(), 4);
      chk("t2_req_valid_low", req_valid, 0);
      insn_ready = 1'b1;
      step();
      insn_ready = 1'b0;
      repeat (8) step();
      chk("t2_hs_count_after_one_pop", hs_addr.size(), 5);

      // Redirect with 3 requests outstanding
      drain("t3_drain");
      req_ready = 1'b1; lat = 5;
      repeat (3) step();
      chk("t3_outstanding", dut_a.outstanding_reg, 3);
      redirect = 1'b1; redirect_pc = 32'h0000_2002;
      step();
      redirect = 1'b0;
      clear_logs();
      repeat (20) step();
      chk("t3_hs_seen", hs_addr.size() != 0, 1);
      if (hs_addr.size() != 0) chk("t3_first_addr", hs_addr[0], 32'h2000);
      chk("t3_pop_seen", pops.size() != 0, 1);
      if (pops.size() != 0) chk("t3_first_pc", pops[0].pc, 32'h2000);

      // Redirect coinciding with a response and a pop
      lat = 2; insn_ready = 1'b1; req_ready = 1'b1;
      found = 0;
      for (int i = 0; i < 40 && found == 0; i++) begin
         if (pend.size() >= 2 && pend[0].due <= cyc && insn_valid) begin
            found = 1;
            redirect = 1'b1; redirect_pc = 32'h0000_3000;
            step();
            redirect = 1'b0;
            chk("t4_insn_valid", insn_valid, 0);
            chk("t4_count", dut_a.count_reg, 0);
            chk("t4_discard", dut_a.discard_reg, pend.size());
         end else begin
            step();
         end
      end
      chk("t4_condition_reached", found, 1);
      repeat (10) step();

      // Pre-decode of a legal and a compressed word
      redirect = 1'b1; redirect_pc = 32'h0000_4000;
      step();
      redirect = 1'b0;
      clear_logs();
      repeat (15) step();
      f0 = 1'b0; f4 = 1'b0;
      foreach (pops[i]) begin
         if (pops[i].pc == 32'h4000 && !f0) begin
            f0 = 1'b1;
            chk("t5_opcode_addi", pops[i].opc, 7'h13);
            chk("t5_legal_addi", pops[i].ill, 0);
         end
         if (pops[i].pc == 32'h4004 && !f4) begin
            f4 = 1'b1;
            chk("t5_illegal_c", pops[i].ill, 1);
         end
      end
      chk("t5_seen", {f0, f4}, 2'b11);

      // Mid-stream reset of the wrapping instance
      rst_b = 1'b1;
      step();
      chk("b_midrst_req_valid", req_valid_b, 0);
      chk("b_midrst_insn_valid", insn_valid_b, 0);
      step();
      rst_b = 1'b0;
      hsb_addr.delete();
      repeat (3) step();
      chk("b_resume_seen", hsb_addr.size() != 0, 1);
      if (hsb_addr.size() != 0) chk("b_resume_addr", hsb_addr[0], RPC_B);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
